// File: rtl/dm_access_unit.sv
`default_nettype none
// ============================================================================
// dm_access_unit : byte/half/word load-store unit over a word-wide big-endian
//                  data memory; sub-word stores use a two-cycle read-modify-write
// Revision: 1.0
// ============================================================================
module dm_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    output logic              dm_we,
    input  logic [31:0]       dm_rdata
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RMW = 1'b1} state_t;

    state_t              state_q, state_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          off_q, off_d;
    logic [1:0]          size_q, size_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         merged_q, merged_d;

    logic                w_err;
    logic [ADDR_W-1:0]   w_aligned;
    logic [31:0]         w_load;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;

    // Lane 0 is the most significant byte (big-endian); only byte/half reach here.
    function automatic logic [31:0] merge_lanes(input logic [31:0] base,
                                                input logic [31:0] data,
                                                input logic [1:0]  off,
                                                input logic [1:0]  size);
        logic [31:0] w;
        w = base;
        if (size == SZ_BYTE) begin
            case (off)
                2'd0:    w[31:24] = data[7:0];
                2'd1:    w[23:16] = data[7:0];
                2'd2:    w[15:8]  = data[7:0];
                default: w[7:0]   = data[7:0];
            endcase
        end else if (off[1]) begin
            w[15:0] = data[15:0];
        end else begin
            w[31:16] = data[15:0];
        end
        return w;
    endfunction

    assign w_err = (req_size == 2'b11) ||
                   ((req_size == SZ_HALF) && req_addr[0]) ||
                   ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign w_aligned = {req_addr[ADDR_W-1:2], 2'b00};

    always_comb begin
        case (req_addr[1:0])
            2'd0:    w_byte = dm_rdata[31:24];
            2'd1:    w_byte = dm_rdata[23:16];
            2'd2:    w_byte = dm_rdata[15:8];
            default: w_byte = dm_rdata[7:0];
        endcase
        w_half = req_addr[1] ? dm_rdata[15:0] : dm_rdata[31:16];
        case (req_size)
            SZ_BYTE: w_load = {{24{~req_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: w_load = {{16{~req_unsigned & w_half[15]}}, w_half};
            default: w_load = dm_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        addr_d      = addr_q;
        off_d       = off_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        merged_d    = merged_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else if (!req_we) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = w_load;
                    end else if (req_size == SZ_WORD) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        addr_d   = w_aligned;
                        off_d    = req_addr[1:0];
                        size_d   = req_size;
                        wdata_d  = req_wdata;
                        merged_d = merge_lanes(dm_rdata, req_wdata, req_addr[1:0], req_size);
                        state_d  = ST_RMW;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            off_q       <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            merged_q    <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            addr_q      <= addr_d;
            off_q       <= off_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            merged_q    <= merged_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign dm_addr   = (state_q == ST_RMW) ? addr_q : w_aligned;
    // Re-applying the latched lanes onto the captured word is idempotent.
    assign dm_wdata  = (state_q == ST_RMW) ? merge_lanes(merged_q, wdata_q, off_q, size_q)
                                           : req_wdata;
    assign dm_we     = ~rst & ((state_q == ST_RMW) ||
                               (req_valid && req_we && (req_size == SZ_WORD) && !w_err));

endmodule
`default_nettype wire

// File: tb/tb_dm_access_unit.sv
`default_nettype none
// ============================================================================
// tb_dm_access_unit : randomized + directed bench against a byte-array model
// Revision: 1.0
// ============================================================================
module tb_dm_access_unit;

    logic        clk, rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, dm_we;
    logic [31:0] rsp_rdata, dm_addr, dm_wdata, dm_rdata;

    logic [31:0] mem [0:63];
    logic [7:0]  ref_b [0:255];
    int          errors = 0;
    int          checks = 0;

    dm_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_we(dm_we), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    assign dm_rdata = mem[dm_addr[7:2]];
    always @(posedge clk) if (dm_we) mem[dm_addr[7:2]] <= dm_wdata;

    function automatic logic [31:0] ref_word(input int a);
        int b;
        b = a & 32'hFC;
        return {ref_b[b], ref_b[b+1], ref_b[b+2], ref_b[b+3]};
    endfunction

    task automatic check_mem(input int a);
        checks++;
        if (mem[(a >> 2) & 63] !== ref_word(a)) begin
            errors++;
            $display("FAIL mem[0x%02h]: got %08h expected %08h", a & 32'hFC, mem[(a >> 2) & 63], ref_word(a));
        end
    endtask

    // Called and returns at a negative clock edge; leaves req_valid low.
    task automatic issue(input bit we, input bit [1:0] size, input bit uns,
                         input int addr, input logic [31:0] wdata);
        int          n;
        bit          err, subw;
        logic [31:0] v, exp;
        n    = 1 << size;
        err  = (size == 2'b11) || ((addr % n) != 0);
        subw = we && !err && (size != 2'b10);
        v = 0;
        if (!err) for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_b[addr + i]);
        exp = v;
        if (!uns && n < 4 && v[8*n-1]) exp = v | (32'hFFFF_FFFF << (8*n));
        if (err || we) exp = 0;

        req_valid = 1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        #1;
        checks += 3;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL accept_ready @%02h: got %b expected 1", addr, req_ready); end
        if (dm_addr !== (addr & 32'hFFFF_FFFC)) begin errors++; $display("FAIL dm_addr @%02h: got %08h expected %08h", addr, dm_addr, addr & 32'hFFFF_FFFC); end
        if (dm_we !== (we && !err && size == 2'b10)) begin errors++; $display("FAIL accept_we @%02h: got %b expected %b", addr, dm_we, we && !err && size == 2'b10); end
        @(negedge clk);
        if (subw) begin
            checks += 4;
            if (req_ready !== 1'b0) begin errors++; $display("FAIL rmw_ready @%02h: got %b expected 0", addr, req_ready); end
            if (dm_we !== 1'b1) begin errors++; $display("FAIL rmw_we @%02h: got %b expected 1", addr, dm_we); end
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmw_rsp_valid @%02h: got %b expected 0", addr, rsp_valid); end
            if (dm_addr !== (addr & 32'hFFFF_FFFC)) begin errors++; $display("FAIL rmw_addr @%02h: got %08h expected %08h", addr, dm_addr, addr & 32'hFFFF_FFFC); end
            @(negedge clk);
        end
        checks += 3;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rsp_valid @%02h: got %b expected 1", addr, rsp_valid); end
        if (rsp_err !== err) begin errors++; $display("FAIL rsp_err @%02h: got %b expected %b", addr, rsp_err, err); end
        if (rsp_rdata !== exp) begin errors++; $display("FAIL rsp_rdata @%02h sz%0d: got %08h expected %08h", addr, size, rsp_rdata, exp); end
        if (we && !err)
            for (int i = 0; i < n; i++) ref_b[addr + i] = 8'(wdata >> (8 * (n - 1 - i)));
        req_valid = 0;
    endtask

    task automatic check_idle_rsp(input string tag);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL %s idle rsp_valid: got %b expected 0", tag, rsp_valid); end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks += 5;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset rsp_valid: got %b expected 0", rsp_valid); end
        if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset rsp_err: got %b expected 0", rsp_err); end
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset rsp_rdata: got %08h expected 0", rsp_rdata); end
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready: got %b expected 1", req_ready); end
        if (dm_we !== 1'b0) begin errors++; $display("FAIL reset dm_we: got %b expected 0", dm_we); end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_loads;
        issue(1, 2'b10, 0, 32'h10, 32'h1122_3344);
        for (int a = 32'h10; a < 32'h14; a++) issue(0, 2'b00, 0, a, 0);
        issue(1, 2'b10, 0, 32'h10, 32'h80FF_0000);
        issue(0, 2'b00, 0, 32'h11, 0);
        issue(0, 2'b00, 1, 32'h11, 0);
        issue(1, 2'b10, 0, 32'h10, 32'h1122_F344);
        issue(0, 2'b01, 0, 32'h12, 0);
        issue(0, 2'b01, 1, 32'h12, 0);
        issue(0, 2'b10, 0, 32'h10, 0);
        check_idle_rsp("loads");
    endtask

    task automatic test_subword_store;
        issue(1, 2'b10, 0, 32'h20, 32'h1122_3344);
        issue(1, 2'b00, 0, 32'h21, 32'h0000_00AB);
        check_mem(32'h20);
        issue(1, 2'b01, 0, 32'h22, 32'h0000_BEEF);
        check_mem(32'h20);
        checks++;
        if (mem[8] !== 32'h11AB_BEEF) begin errors++; $display("FAIL sh_result: got %08h expected 11abbeef", mem[8]); end
        check_idle_rsp("subword");
    endtask

    task automatic test_errors;
        issue(0, 2'b01, 0, 32'h13, 0);
        issue(0, 2'b10, 0, 32'h12, 0);
        issue(0, 2'b11, 0, 32'h14, 0);
        issue(1, 2'b11, 0, 32'h14, 32'hFFFF_FFFF);
        issue(1, 2'b01, 0, 32'h15, 32'hFFFF_FFFF);
        issue(1, 2'b10, 0, 32'h16, 32'hFFFF_FFFF);
        check_mem(32'h10);
        check_mem(32'h14);
        check_idle_rsp("errors");
    endtask

    task automatic test_back_to_back;
        issue(1, 2'b10, 0, 32'h30, 32'hDEAD_BEEF);
        issue(0, 2'b10, 0, 32'h30, 0);
        issue(1, 2'b00, 0, 32'h33, 32'h0000_0012);
        issue(0, 2'b10, 0, 32'h30, 0);
        for (int i = 0; i < 8; i++) issue(0, 2'(i % 3), i[0], 32'h30 + (i % 3 == 2 ? 0 : i % 3 * 2), 0);
        check_idle_rsp("b2b");
    endtask

    task automatic test_reset_rmw;
        issue(1, 2'b10, 0, 32'h40, 32'hCAFE_F00D);
        req_valid = 1; req_we = 1; req_size = 2'b00; req_unsigned = 0;
        req_addr = 32'h40; req_wdata = 32'h55;
        @(negedge clk);
        rst = 1;
        #1;
        checks++;
        if (dm_we !== 1'b0) begin errors++; $display("FAIL rst_rmw dm_we: got %b expected 0", dm_we); end
        req_valid = 0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rmw rsp_valid: got %b expected 0", rsp_valid); end
        rst = 0;
        @(negedge clk);
        checks += 2;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_rmw req_ready: got %b expected 1", req_ready); end
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rmw post rsp_valid: got %b expected 0", rsp_valid); end
        check_mem(32'h40);
    endtask

    task automatic test_random;
        for (int k = 0; k < 300; k++) begin
            bit [1:0] sz;
            int       a;
            sz = 2'($urandom_range(0, 3));
            a  = $urandom_range(0, 252);
            if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((1 << sz) - 1);
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 7) == 0) check_idle_rsp("random");
        end
        for (int w = 0; w < 64; w++) check_mem(w * 4);
    endtask

    initial begin
        clk = 0; rst = 1; req_valid = 0; req_we = 0; req_size = 0;
        req_unsigned = 0; req_addr = 0; req_wdata = 0;
        for (int w = 0; w < 64; w++) begin
            mem[w] = $urandom;
            for (int b = 0; b < 4; b++) ref_b[w*4 + b] = 8'(mem[w] >> (8 * (3 - b)));
        end
        test_reset;
        test_loads;
        test_subword_store;
        test_errors;
        test_back_to_back;
        test_reset_rmw;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dm_access_unit.md
# dm_access_unit

Load/store access unit between the MEM pipeline stage and the word-wide, byte-addressed, big-endian data memory. It turns byte, halfword and word loads and stores into aligned word accesses. Sub-word loads are extracted and extended. Sub-word stores use a two-cycle read-modify-write, because the data memory only writes whole words.

## Interface
- ADDR_W, 32, width of request and memory address buses
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  access request from the MEM stage
- req_ready  out  1  unit can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified (byte in [7:0], halfword in [15:0])
- rsp_valid  out  1  one-cycle pulse: access complete
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors
- rsp_err  out  1  misaligned or reserved-size request, valid with rsp_valid
- dm_addr  out  ADDR_W  word-aligned memory address, always {addr[ADDR_W-1:2],2'b00}
- dm_wdata  out  32  full word written to memory
- dm_we  out  1  memory write enable; memory writes on the clk rising edge
- dm_rdata  in  32  combinational memory read of the word at dm_addr

## Operation
- Byte lanes are big-endian: offset 0 = [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0]. Halfword offset 0 = [31:16], offset 2 = [15:0].
- Alignment check: a halfword with addr[0]=1, a word with addr[1:0]≠0, or any size=11 is an error. An error causes no memory access (dm_we=0), then rsp_valid=1, rsp_err=1, rsp_rdata=0.
- States: IDLE, RMW.
- IDLE:
  - req_ready=1.
  - dm_addr is the aligned form of req_addr, combinationally.
  - A request is accepted when req_valid=1 in IDLE.
- Load, accepted in IDLE:
  - Select the lane from dm_rdata and extend it per req_unsigned.
  - Register the result into rsp_rdata.
  - Stay in IDLE.
- Word store, accepted in IDLE:
  - dm_we=1 and dm_wdata=req_wdata in the same cycle.
  - Stay in IDLE.
- Sub-word store, accepted in IDLE:
  - dm_we=0.
  - Latch the aligned address, offset, size and wdata.
  - Merge the store data into the current dm_rdata at the addressed lane(s), keeping all other bytes.
  - Latch the merged word and go to RMW.
- RMW:
  - req_ready=0.
  - dm_addr = latched address, dm_wdata = merged word, dm_we=1.
  - Return to IDLE at the next edge.
- While req_ready=0, upstream holds req_* stable. A request presented during RMW is not accepted and has no effect.
- dm_we is 0 whenever rst=1, and in IDLE with no valid error-free store.

## Timing
- Reset values:
  - State IDLE.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Latched address, offset, size, data and merged word all 0.
- Load: accepted at edge N, rsp_valid and data at cycle N+1. Throughput is 1 per cycle.
- Word store: memory is written at edge N, rsp_valid at N+1. Throughput is 1 per cycle.
- Sub-word store: read at cycle N, write at N+1 (RMW), rsp_valid at N+2. req_ready is low during N+1.
- Error: rsp_valid and rsp_err at N+1, memory untouched.
- rsp_valid is high for exactly one cycle per accepted request and is 0 in all other cycles.
- Back-to-back store then load to the same word: the load at N+1 (or after RMW) returns the new data, because memory was updated at the preceding edge.
- Reset mid-RMW: the write is aborted, memory keeps its pre-store contents, state returns to IDLE, and no rsp_valid is produced.

## Test plan
- After reset, memory word at 0x10 = 0x11223344. Byte loads at 0x10..0x13 (signed) -> 0x00000011, 0x00000022, 0x00000033, 0x00000044. With word = 0x80FF0000, lb at 0x11 -> 0xFFFFFFFF, lbu at 0x11 -> 0x000000FF.
- lh at 0x12 on word 0x1122F344 -> 0xFFFFF344; lhu -> 0x0000F344. lw at 0x10 -> 0x1122F344, rsp_valid one cycle after acceptance.
- sb 0xAB at 0x21 on word 0x11223344 -> req_ready low for one cycle, dm_we only in RMW, word becomes 0x11AB3344, rsp_valid two cycles after acceptance. sh 0xBEEF at 0x22 -> 0x11ABBEEF.
- Misaligned lh at 0x13, lw at 0x12, size=11 -> rsp_err=1, rsp_rdata=0, dm_we never asserted, memory unchanged.
- sw 0xDEADBEEF at 0x30, then lw at 0x30 on the next cycle -> 0xDEADBEEF. Back-to-back loads every cycle -> rsp_valid continuously high.
- Assert rst during the RMW cycle of sb at 0x40 -> memory unchanged, no rsp_valid, req_ready=1 after rst falls.
